// File: rtl/fp_add_sched.sv
// Round-robin arbiter sharing one fixed-latency pipelined FP adder among N_REQ requesters.
// Orders each operand pair by magnitude and routes adder results back to the issuing requester.
module fp_add_sched #(
  parameter int WIDTH = 32,
  parameter int N_REQ = 4,
  parameter int LAT   = 3,
  parameter int IDW   = 2
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   en,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  input  logic [N_REQ-1:0]       req_sub,
  output logic                   add_valid,
  output logic [WIDTH-1:0]       OP_L,
  output logic [WIDTH-1:0]       OP_S,
  input  logic                   res_valid,
  input  logic [WIDTH-1:0]       res_data,
  output logic [N_REQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]       rsp_data,
  output logic                   busy,
  output logic                   err
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e             state_q, state_d;
  logic [IDW-1:0]     ptr_q;
  logic               add_valid_q;
  logic [WIDTH-1:0]   op_l_q, op_s_q;
  logic [IDW-1:0]     id_q;
  logic [LAT-1:0]     tag_v_q;
  logic [IDW-1:0]     tag_id_q [LAT];
  logic [N_REQ-1:0]   rsp_valid_q;
  logic [WIDTH-1:0]   rsp_data_q;
  logic               err_q;

  logic               run_ok;
  logic               pipe_empty;
  logic               gnt_found;
  logic [IDW-1:0]     gnt_id;
  logic [WIDTH-1:0]   a_sel, b_sel, b_eff;
  logic               sub_sel;
  logic               a_big;
  logic               xfer;
  int                 idx;

  assign pipe_empty = ~|tag_v_q;

  always_ff @(posedge CLK) begin
    if (!RST) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    run_ok  = 1'b0;
    case (state_q)
      IDLE:    if (en) state_d = RUN;
      RUN: begin
        run_ok = en;
        if (!en) state_d = DRAIN;
      end
      DRAIN: begin
        if (en)              state_d = RUN;
        else if (pipe_empty) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Scan starts one past the last winner, so the last winner has lowest priority.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    a_sel     = '0;
    b_sel     = '0;
    sub_sel   = 1'b0;
    idx       = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(ptr_q) + k) % N_REQ;
      if (!gnt_found && req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_id    = IDW'(idx);
        a_sel     = req_a[idx*WIDTH +: WIDTH];
        b_sel     = req_b[idx*WIDTH +: WIDTH];
        sub_sel   = req_sub[idx];
      end
    end
    req_ready = '0;
    if (run_ok && gnt_found) req_ready[gnt_id] = 1'b1;
  end

  assign xfer  = run_ok & gnt_found;
  assign b_eff = {b_sel[WIDTH-1] ^ sub_sel, b_sel[WIDTH-2:0]};
  assign a_big = a_sel[WIDTH-2:0] >= b_eff[WIDTH-2:0];

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      ptr_q       <= IDW'(N_REQ - 1);
      add_valid_q <= 1'b0;
      op_l_q      <= '0;
      op_s_q      <= '0;
      id_q        <= '0;
    end else begin
      add_valid_q <= xfer;
      if (xfer) begin
        ptr_q  <= gnt_id;
        id_q   <= gnt_id;
        op_l_q <= a_big ? a_sel : b_eff;
        op_s_q <= a_big ? b_eff : a_sel;
      end
    end
  end

  // NOTE: the tag pipe is reset because its valid bits decide whether a result is delivered.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      tag_v_q <= '0;
      for (int i = 0; i < LAT; i++) tag_id_q[i] <= '0;
    end else begin
      tag_v_q[0]  <= add_valid_q;
      tag_id_q[0] <= id_q;
      for (int i = 1; i < LAT; i++) begin
        tag_v_q[i]  <= tag_v_q[i-1];
        tag_id_q[i] <= tag_id_q[i-1];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      rsp_valid_q <= '0;
      if (tag_v_q[LAT-1]) begin
        rsp_valid_q[tag_id_q[LAT-1]] <= 1'b1;
        rsp_data_q                   <= res_data;
      end
      err_q <= err_q | (res_valid != tag_v_q[LAT-1]);
    end
  end

  assign add_valid = add_valid_q;
  assign OP_L      = op_l_q;
  assign OP_S      = op_s_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign err       = err_q;
  assign busy      = (state_q != IDLE) | ~pipe_empty | add_valid_q;

endmodule

// File: tb/tb_fp_add_sched.sv
// Self-checking bench for fp_add_sched: directed steps plus random traffic against a
// transaction-level round-robin/ordering model and a behavioural fixed-latency adder.
module tb_fp_add_sched;

  localparam int W = 32;
  localparam int N = 4;
  localparam int L = 3;

  logic             CLK = 1'b0;
  logic             RST = 1'b0;
  logic             en  = 1'b0;
  logic [N-1:0]     req_valid = '0;
  logic [N-1:0]     req_sub   = '0;
  logic [N*W-1:0]   req_a = '0;
  logic [N*W-1:0]   req_b = '0;
  logic             res_valid = 1'b0;
  logic [W-1:0]     res_data  = '0;
  logic [N-1:0]     req_ready;
  logic             add_valid;
  logic [W-1:0]     OP_L, OP_S;
  logic [N-1:0]     rsp_valid;
  logic [W-1:0]     rsp_data;
  logic             busy, err;

  fp_add_sched #(.WIDTH(W), .N_REQ(N), .LAT(L), .IDW(2)) dut (
    .CLK(CLK), .RST(RST), .en(en),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sub(req_sub),
    .add_valid(add_valid), .OP_L(OP_L), .OP_S(OP_S),
    .res_valid(res_valid), .res_data(res_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .busy(busy), .err(err)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    int          id;
    logic [31:0] data;
  } rsp_t;

  rsp_t exp_q[$];
  rsp_t act_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  // Single-precision add evaluated in double precision, truncated back to single.
  function automatic real s2r(input logic [31:0] x);
    logic [10:0] e;
    if (x[30:0] == 31'd0) return 0.0;
    e = {3'b000, x[30:23]} + 11'd896;
    return $bitstoreal({x[31], e, x[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] r2s(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:52] == 11'd0) return {d[63], 31'd0};
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fadd(input logic [31:0] x, input logic [31:0] y);
    return r2s(s2r(x) + s2r(y));
  endfunction

  function automatic logic [31:0] rand_f();
    return {1'($urandom), 8'($urandom_range(120, 134)), 23'($urandom)};
  endfunction

  // Adder model: result appears LAT cycles after add_valid; inject forces a stray strobe.
  logic        av_h [0:L] = '{default: 1'b0};
  logic [31:0] ad_h [0:L] = '{default: 32'd0};
  logic        inject = 1'b0;

  always @(negedge CLK) begin
    for (int i = L; i > 0; i--) begin
      av_h[i] = av_h[i-1];
      ad_h[i] = ad_h[i-1];
    end
    av_h[0] = add_valid;
    ad_h[0] = fadd(OP_L, OP_S);
    if (!RST) for (int i = 0; i <= L; i++) av_h[i] = 1'b0;
    res_valid = av_h[L] | inject;
    res_data  = ad_h[L];
  end

  always @(negedge CLK) begin
    rsp_t r;
    if (RST && rsp_valid != '0) begin
      r.cyc  = cyc;
      r.id   = -1;
      for (int i = 0; i < N; i++)
        if (rsp_valid[i]) r.id = (r.id == -1) ? i : 99;
      r.data = rsp_data;
      act_q.push_back(r);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: got %h, expected %h", tag, obs, exp_v);
    end
  endtask

  // Reference model state
  int          m_ptr   = N - 1;
  bit          prev_en = 1'b0;
  bit          exp_xfer;
  int          last_gnt;
  logic [31:0] exp_l, exp_s;

  // One clock: check the combinational grant, predict the transfer, then check the issue.
  task automatic step();
    bit          run_ok;
    int          gid;
    logic [31:0] a, b;
    logic [N-1:0] er;
    rsp_t        r;
    #1;
    run_ok = prev_en && en && RST;
    gid    = -1;
    er     = '0;
    if (run_ok)
      for (int k = 1; k <= N; k++)
        if (gid < 0 && req_valid[(m_ptr + k) % N]) gid = (m_ptr + k) % N;
    if (gid >= 0) er[gid] = 1'b1;
    check("req_ready", 32'(req_ready), 32'(er));
    exp_xfer = (gid >= 0);
    last_gnt = gid;
    if (exp_xfer) begin
      a = req_a[gid*W +: W];
      b = req_b[gid*W +: W];
      b[31] = b[31] ^ req_sub[gid];
      if (a[30:0] >= b[30:0]) begin exp_l = a; exp_s = b; end
      else                    begin exp_l = b; exp_s = a; end
      m_ptr  = gid;
      r.cyc  = cyc + L + 2;
      r.id   = gid;
      r.data = fadd(a, b);
      exp_q.push_back(r);
    end
    if (!RST) begin
      m_ptr = N - 1;
      while (exp_q.size() > 0 && exp_q[$].cyc > cyc) void'(exp_q.pop_back());
    end
    @(posedge CLK);
    #1;
    prev_en = RST ? en : 1'b0;
    check("add_valid", 32'(add_valid), 32'(exp_xfer));
    if (exp_xfer) begin
      check("op_l", OP_L, exp_l);
      check("op_s", OP_S, exp_s);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic compare_rsp(input string tag);
    check({tag, "_rsp_count"}, 32'(act_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      check({tag, "_rsp_cycle"}, 32'(act_q[i].cyc), 32'(exp_q[i].cyc));
      check({tag, "_rsp_id"},    32'(act_q[i].id),  32'(exp_q[i].id));
      check({tag, "_rsp_data"},  act_q[i].data,     exp_q[i].data);
    end
    exp_q.delete();
    act_q.delete();
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = rand_f();
      req_b[i*W +: W] = rand_f();
    end
    req_sub = N'($urandom);
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic s);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_sub[i]      = s;
    req_valid       = '0;
    req_valid[i]    = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int fall;
    int last_due;

    // Reset state
    @(posedge CLK);
    #1;
    idle(2);
    check("rst_add_valid", 32'(add_valid), 32'd0);
    check("rst_op_l", OP_L, 32'd0);
    check("rst_op_s", OP_S, 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);

    // 2.0 + 1.0 from requester 0
    RST = 1'b1;
    en  = 1'b1;
    idle(1);
    set_req(0, 32'h40000000, 32'h3F800000, 1'b0);
    step();
    req_valid = '0;
    check("t1_op_l", OP_L, 32'h40000000);
    check("t1_op_s", OP_S, 32'h3F800000);
    idle(L + 3);
    if (act_q.size() > 0) check("t1_rsp_data_lit", act_q[0].data, 32'h40400000);
    compare_rsp("t1");

    // 1.0 - 2.0 from requester 1: operands swap, B sign flips
    set_req(1, 32'h3F800000, 32'h40000000, 1'b1);
    step();
    req_valid = '0;
    check("t2_op_l", OP_L, 32'hC0000000);
    check("t2_op_s", OP_S, 32'h3F800000);
    idle(L + 3);
    compare_rsp("t2");

    // Equal magnitudes from requester 3: A wins the tie
    set_req(3, 32'h3F800000, 32'hBF800000, 1'b0);
    step();
    req_valid = '0;
    check("t3_op_l", OP_L, 32'h3F800000);
    check("t3_op_s", OP_S, 32'hBF800000);
    idle(L + 3);
    compare_rsp("t3");

    // All requesters held valid for 8 cycles
    req_valid = '1;
    for (int i = 0; i < 8; i++) begin
      rand_ops();
      step();
      check("rr_order", 32'(last_gnt), 32'(i % N));
    end
    req_valid = '0;
    idle(L + 4);
    compare_rsp("rr");

    // Random traffic with occasional en drops
    for (int i = 0; i < 60; i++) begin
      rand_ops();
      req_valid = N'($urandom);
      en = ($urandom_range(0, 7) != 0);
      step();
    end
    en = 1'b1;
    req_valid = '0;
    idle(L + 6);
    compare_rsp("rand");
    check("rand_err", 32'(err), 32'd0);

    // Drain: three back-to-back issues, then en drops with requests still pending
    req_valid = '1;
    for (int i = 0; i < 3; i++) begin
      rand_ops();
      step();
    end
    en = 1'b0;
    step();
    req_valid = '0;
    last_due = (exp_q.size() > 0) ? exp_q[$].cyc : -100;
    fall = -1;
    for (int k = 0; k < 20 && fall < 0; k++) begin
      step();
      if (!busy) fall = cyc;
    end
    check("drain_rsp_total", 32'(act_q.size()), 32'd3);
    check("drain_busy_fall", 32'(fall), 32'(last_due + 1));
    compare_rsp("drain");

    // Reset with two operations in flight
    en = 1'b1;
    idle(1);
    rand_ops();
    req_valid = 4'b0011;
    idle(2);
    req_valid = '0;
    step();
    RST = 1'b0;
    step();
    check("mid_rst_add_valid", 32'(add_valid), 32'd0);
    check("mid_rst_op_l", OP_L, 32'd0);
    check("mid_rst_op_s", OP_S, 32'd0);
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_rsp_data", rsp_data, 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_err", 32'(err), 32'd0);
    RST = 1'b1;
    en  = 1'b0;
    idle(L + 6);
    compare_rsp("mid_rst");
    check("post_rst_err", 32'(err), 32'd0);

    // Spurious adder result sets the sticky error
    inject = 1'b1;
    step();
    inject = 1'b0;
    step();
    check("err_set", 32'(err), 32'd1);
    idle(5);
    check("err_sticky", 32'(err), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
